// File: rtl/dct_transpose_buf.sv
// dct_transpose_buf: ping-pong 8x8 transpose buffer between the row pass and
// the column pass of a 2-D 8-point DCT. Rows are written in (saturated to
// OUT_W bits), columns are read out, two banks alternate so a continuous
// stream flows with no bubbles.
//
// Handshake: a transfer happens on a rising clk edge exactly when valid and
// ready are both high. valid never depends on ready; in_ready and out_valid
// are decoded from registered bank flags only, so no combinational path
// exists from in_* to out_* or from out_ready to in_ready.
module dct_transpose_buf #(
    parameter int IN_W  = 14,
    parameter int OUT_W = 13
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*IN_W-1:0]    in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*OUT_W-1:0]   out_data,
    output logic [2:0]           out_col,
    output logic                 out_last
);

    // Clamp a signed IN_W coefficient into the signed OUT_W range.
    function automatic logic [OUT_W-1:0] sat(input logic signed [IN_W-1:0] v);
        logic signed [IN_W-1:0] hi;
        logic signed [IN_W-1:0] lo;
        hi = IN_W'((1 << (OUT_W - 1)) - 1);
        lo = ~hi;
        if (v > hi) begin
            sat = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (v < lo) begin
            sat = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            sat = v[OUT_W-1:0];
        end
    endfunction

    // Bank flags (full = FULL/DRAINING, empty = EMPTY/FILLING), pointers, counters
    logic [1:0] full_q,    full_d;
    logic       wr_bank_q, wr_bank_d;
    logic       rd_bank_q, rd_bank_d;
    logic [2:0] wr_row_q,  wr_row_d;
    logic [2:0] rd_col_q,  rd_col_d;

    // Storage: [bank][row][column]; not reset, flags decide what is valid
    logic [OUT_W-1:0] mem_q [2][8][8];

    logic wr_en;
    logic rd_en;

    // A bank is only written while its flag is clear, so the bank being read
    // (flag set) is never disturbed and out_data holds during stalls.
    assign in_ready  = !full_q[wr_bank_q];
    assign out_valid = full_q[rd_bank_q];
    assign wr_en     = in_valid && in_ready;
    assign rd_en     = out_valid && out_ready;

    // Next-state for flags, pointers and counters; write-set and read-clear
    // always target different banks so both may happen in one cycle.
    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_row_d  = wr_row_q;
        rd_col_d  = rd_col_q;
        if (wr_en) begin
            wr_row_d = wr_row_q + 3'd1;
            if (wr_row_q == 3'd7) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
            end
        end
        if (rd_en) begin
            rd_col_d = rd_col_q + 3'd1;
            if (rd_col_q == 3'd7) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = !rd_bank_q;
            end
        end
    end

    // Control state register with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q    <= 2'b00;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_row_q  <= 3'd0;
            rd_col_q  <= 3'd0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_row_q  <= wr_row_d;
            rd_col_q  <= rd_col_d;
        end
    end

    // Store one saturated row into the bank being filled
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < 8; k++) begin
                mem_q[wr_bank_q][wr_row_q][3'(k)] <= sat(in_data[IN_W*k +: IN_W]);
            end
        end
    end

    // Present the current column of the bank being drained, zero when idle
    always_comb begin
        out_data = '0;
        out_col  = 3'd0;
        out_last = 1'b0;
        if (out_valid) begin
            for (int r = 0; r < 8; r++) begin
                out_data[OUT_W*r +: OUT_W] = mem_q[rd_bank_q][3'(r)][rd_col_q];
            end
            out_col  = rd_col_q;
            out_last = (rd_col_q == 3'd7);
        end
    end

endmodule

// File: tb/tb_dct_transpose_buf.sv
// tb_dct_transpose_buf: directed scenarios for the ping-pong transpose buffer.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_dct_transpose_buf;

    localparam int IN_W  = 14;
    localparam int OUT_W = 13;

    logic                 clk;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [8*IN_W-1:0]    in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [8*OUT_W-1:0]   out_data;
    logic [2:0]           out_col;
    logic                 out_last;

    int errors = 0;
    int checks = 0;

    // Reference transpose model used by the random-stall scenario
    logic [8*OUT_W-1:0] exp_q[$];
    logic [OUT_W-1:0]   mdl_blk [8][8];
    int                 mdl_row = 0;
    int                 mdl_col = 0;

    dct_transpose_buf #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_col   (out_col),
        .out_last  (out_last)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Row r of block b: coefficient c = 16*r + c + 128*b
    function automatic logic [8*IN_W-1:0] mk_row(input int b, input int r);
        logic [8*IN_W-1:0] d;
        for (int c = 0; c < 8; c++) d[IN_W*c +: IN_W] = IN_W'(16*r + c + 128*b);
        return d;
    endfunction

    // Column c of block b as the transpose of mk_row
    function automatic logic [8*OUT_W-1:0] mk_col(input int b, input int c);
        logic [8*OUT_W-1:0] d;
        for (int r = 0; r < 8; r++) d[OUT_W*r +: OUT_W] = OUT_W'(16*r + c + 128*b);
        return d;
    endfunction

    function automatic logic [OUT_W-1:0] sat_ref(input int v);
        if (v > 4095) return OUT_W'(4095);
        if (v < -4096) return OUT_W'(-4096);
        return OUT_W'(v);
    endfunction

    task automatic model_push_row(input logic [8*IN_W-1:0] d);
        logic [8*OUT_W-1:0] col;
        int v;
        for (int k = 0; k < 8; k++) begin
            v = int'($signed(d[IN_W*k +: IN_W]));
            mdl_blk[mdl_row][k] = sat_ref(v);
        end
        mdl_row++;
        if (mdl_row == 8) begin
            for (int c = 0; c < 8; c++) begin
                col = '0;
                for (int r = 0; r < 8; r++) col[OUT_W*r +: OUT_W] = mdl_blk[r][c];
                exp_q.push_back(col);
            end
            mdl_row = 0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        @(negedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        checks++; if (out_col !== 3'd0) begin errors++; $display("FAIL reset_out_col got=%0d exp=0", out_col); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_block();
        out_ready = 1'b1;
        for (int r = 0; r < 8; r++) begin
            in_valid = 1'b1; in_data = mk_row(0, r); #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready row=%0d got=%b exp=1", r, in_ready); end
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid row=%0d got=%b exp=0", r, out_valid); end
            @(negedge clk);
        end
        in_valid = 1'b0; in_data = '0;
        for (int c = 0; c < 8; c++) begin
            #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid col=%0d got=%b exp=1", c, out_valid); end
            checks++; if (out_col !== 3'(c)) begin errors++; $display("FAIL single_col col=%0d got=%0d exp=%0d", c, out_col, c); end
            checks++; if (out_last !== (c == 7)) begin errors++; $display("FAIL single_last col=%0d got=%b exp=%b", c, out_last, c == 7); end
            checks++; if (out_data !== mk_col(0, c)) begin errors++; $display("FAIL single_data col=%0d got=%h exp=%h", c, out_data, mk_col(0, c)); end
            @(negedge clk);
        end
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_after_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL single_after_data got=%h exp=0", out_data); end
        @(negedge clk);
    endtask

    task automatic test_saturation();
        int sat_in[8];
        int sat_exp[8];
        logic [8*IN_W-1:0]  row0;
        logic [8*OUT_W-1:0] ecol;
        sat_in  = '{8191, -8192, 4095, -4096, 4096, -4097, 0, -1};
        sat_exp = '{4095, -4096, 4095, -4096, 4095, -4096, 0, -1};
        for (int k = 0; k < 8; k++) row0[IN_W*k +: IN_W] = IN_W'(sat_in[k]);
        out_ready = 1'b1;
        for (int r = 0; r < 8; r++) begin
            in_valid = 1'b1; in_data = (r == 0) ? row0 : mk_row(1, r);
            @(negedge clk);
        end
        in_valid = 1'b0; in_data = '0;
        for (int c = 0; c < 8; c++) begin
            #1;
            ecol = mk_col(1, c);
            checks++; if (out_data[OUT_W-1:0] !== OUT_W'(sat_exp[c])) begin errors++; $display("FAIL sat_row0 col=%0d got=%h exp=%h", c, out_data[OUT_W-1:0], OUT_W'(sat_exp[c])); end
            checks++; if (out_data[8*OUT_W-1:OUT_W] !== ecol[8*OUT_W-1:OUT_W]) begin errors++; $display("FAIL sat_rows col=%0d got=%h exp=%h", c, out_data[8*OUT_W-1:OUT_W], ecol[8*OUT_W-1:OUT_W]); end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        int acc;
        acc = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_data = mk_row(2 + acc / 8, acc % 8); #1;
            checks++; if (in_ready !== (i < 16)) begin errors++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=%b", i, in_ready, i < 16); end
            checks++; if (out_valid !== (i >= 8)) begin errors++; $display("FAIL bp_out_valid cyc=%0d got=%b exp=%b", i, out_valid, i >= 8); end
            if (in_ready) acc++;
            @(negedge clk);
        end
        checks++; if (acc != 16) begin errors++; $display("FAIL bp_accepted got=%0d exp=16", acc); end
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            #1;
            checks++; if (in_ready !== (j >= 8)) begin errors++; $display("FAIL bp_drain_ready cyc=%0d got=%b exp=%b", j, in_ready, j >= 8); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_drain_valid cyc=%0d got=%b exp=1", j, out_valid); end
            checks++; if (out_data !== mk_col(2 + j / 8, j % 8)) begin errors++; $display("FAIL bp_drain_data cyc=%0d got=%h exp=%h", j, out_data, mk_col(2 + j / 8, j % 8)); end
            @(negedge clk);
        end
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_after_valid got=%b exp=0", out_valid); end
        @(negedge clk);
    endtask

    task automatic test_streaming();
        int j;
        out_ready = 1'b1;
        for (int i = 0; i < 41; i++) begin
            in_valid = (i < 32); in_data = (i < 32) ? mk_row(4 + i / 8, i % 8) : '0; #1;
            if (i < 32) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready cyc=%0d got=%b exp=1", i, in_ready); end
            end
            checks++; if (out_valid !== (i >= 8 && i < 40)) begin errors++; $display("FAIL stream_valid cyc=%0d got=%b exp=%b", i, out_valid, i >= 8 && i < 40); end
            if (i >= 8 && i < 40) begin
                j = i - 8;
                checks++; if (out_col !== 3'(j % 8)) begin errors++; $display("FAIL stream_col cyc=%0d got=%0d exp=%0d", i, out_col, j % 8); end
                checks++; if (out_last !== (j % 8 == 7)) begin errors++; $display("FAIL stream_last cyc=%0d got=%b exp=%b", i, out_last, j % 8 == 7); end
                checks++; if (out_data !== mk_col(4 + j / 8, j % 8)) begin errors++; $display("FAIL stream_data cyc=%0d got=%h exp=%h", i, out_data, mk_col(4 + j / 8, j % 8)); end
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_random_stalls();
        int sent, got, cyc, held;
        sent = 0; got = 0; cyc = 0;
        exp_q.delete(); mdl_row = 0; mdl_col = 0;
        while ((sent < 80 || got < 80) && cyc < 3000) begin
            in_valid = (sent < 80) && ($urandom_range(0, 1) == 1);
            for (int k = 0; k < 8; k++) in_data[IN_W*k +: IN_W] = IN_W'($urandom_range(0, 16383));
            out_ready = ($urandom_range(0, 1) == 1);
            #1;
            held = (exp_q.size() + 7) / 8;
            checks++; if (out_valid !== (exp_q.size() != 0)) begin errors++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_q.size() != 0); end
            checks++; if (in_ready !== (held < 2)) begin errors++; $display("FAIL rand_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, held < 2); end
            if (out_valid && exp_q.size() != 0) begin
                checks++; if (out_data !== exp_q[0]) begin errors++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", cyc, out_data, exp_q[0]); end
                checks++; if (out_col !== 3'(mdl_col)) begin errors++; $display("FAIL rand_col cyc=%0d got=%0d exp=%0d", cyc, out_col, mdl_col); end
                checks++; if (out_last !== (mdl_col == 7)) begin errors++; $display("FAIL rand_last cyc=%0d got=%b exp=%b", cyc, out_last, mdl_col == 7); end
            end else if (!out_valid) begin
                checks++; if (out_data !== '0) begin errors++; $display("FAIL rand_idle_data cyc=%0d got=%h exp=0", cyc, out_data); end
            end
            if (in_valid && in_ready) begin
                model_push_row(in_data);
                sent++;
            end
            if (out_valid && out_ready && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                mdl_col = (mdl_col + 1) % 8;
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        checks++; if (got != 80) begin errors++; $display("FAIL rand_timeout got=%0d exp=80 columns", got); end
    endtask

    task automatic test_reset_mid_fill();
        out_ready = 1'b0;
        for (int i = 0; i < 13; i++) begin
            in_valid = 1'b1; in_data = mk_row(8, i % 8); #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_fill_ready cyc=%0d got=%b exp=1", i, in_ready); end
            @(negedge clk);
        end
        in_valid = 1'b0; in_data = '0; #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid got=%b exp=1", out_valid); end
        rst_n = 1'b0; #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_async_ready got=%b exp=1", in_ready); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL rst_async_data got=%h exp=0", out_data); end
        checks++; if (out_col !== 3'd0) begin errors++; $display("FAIL rst_async_col got=%0d exp=0", out_col); end
        #1 rst_n = 1'b1;
        @(negedge clk);
        out_ready = 1'b1;
        for (int r = 0; r < 8; r++) begin
            in_valid = 1'b1; in_data = mk_row(9, r); #1;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_refill_valid row=%0d got=%b exp=0", r, out_valid); end
            @(negedge clk);
        end
        in_valid = 1'b0; in_data = '0;
        for (int c = 0; c < 8; c++) begin
            #1;
            checks++; if (out_data !== mk_col(9, c)) begin errors++; $display("FAIL rst_refill_data col=%0d got=%h exp=%h", c, out_data, mk_col(9, c)); end
            checks++; if (out_last !== (c == 7)) begin errors++; $display("FAIL rst_refill_last col=%0d got=%b exp=%b", c, out_last, c == 7); end
            @(negedge clk);
        end
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_refill_after got=%b exp=0", out_valid); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_saturation();
        test_backpressure();
        test_streaming();
        test_random_stalls();
        test_reset_mid_fill();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
